seq_divider: RTL

//   Sequential restoring unsigned divider; the inverse companion of the shift-add

---
 rtl/seq_divider.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Purpose:
//   Divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor.
//   Each clock performs one shift and one trial subtraction, so a division
//   takes WIDTH iterations. A zero divisor skips the iterations and reports
//   div_by_zero with an all-ones quotient and the dividend as remainder.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset, aborts any division in flight
//   start        in   request, accepted in IDLE or DONE
//   dividend     in   WIDTH-bit dividend, sampled with accepted start
//   divisor      in   WIDTH-bit divisor, sampled with accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse when results are valid
//   quotient     out  WIDTH-bit quotient, held until next done
//   remainder    out  WIDTH-bit remainder, held until next done
//   div_by_zero  out  set with done when the divisor was zero

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // The shifted remainder keeps the bit that falls out of R, so divisors with
  // the top bit set still see the true partial remainder (it is always below
  // twice the divisor, hence fits in WIDTH+1 bits).
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, dvsr_q};
    r_d     = r_shift[WIDTH-1:0];
    q_d     = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_d     = trial[WIDTH-1:0];
      q_d[0]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            q_q    <= dividend;
            r_q    <= '0;
            dvsr_q <= divisor;
            cnt_q  <= '0;
            if (divisor == '0) begin
              // No iterations: results are known immediately.
              state_q     <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= CALC;
              busy    <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Results are taken from the final iteration's next-state values.
            state_q     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_d;
            remainder   <= r_d;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
